// File: rtl/imm_gen_pipe_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_pkg
// Shared definitions for the registered RISC-V immediate generator:
//   - imm_sel_e : ImmSel format codes carried on out_sel
//   - OPC_*     : major opcodes (inst[6:0]) recognised by the decoder
// No ports; imported by imm_gen_comb and imm_gen_pipe.
// -----------------------------------------------------------------------------
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    IMM_R    = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_JAL  = 3'd5,
    IMM_JALR = 3'd6,
    IMM_CSR  = 3'd7
  } imm_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_comb.sv
// -----------------------------------------------------------------------------
// imm_gen_comb
// Purely combinational immediate decoder: instruction word -> {ImmSel, imm}.
// Every format is first assembled as a 32-bit value and then sign-extended to
// XLEN, so the same code serves XLEN=32 and XLEN=64 (CSR zimm has bit 31 = 0,
// which makes the sign extension a zero extension for that format).
// Optional macro IMM_GEN_ILLEGAL_EN adds the 'illegal' output.
// Ports:
//   inst    in  32    instruction word
//   sel     out 3     ImmSel format code (unknown opcodes -> R)
//   imm     out XLEN  extended immediate (0 for R)
//   illegal out 1     opcode not recognised (only with IMM_GEN_ILLEGAL_EN)
// -----------------------------------------------------------------------------
module imm_gen_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [2:0]      sel,
  output logic [XLEN-1:0] imm
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  imm_sel_e    sel_s;
  logic [31:0] raw_s;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Opcode classification and 32-bit immediate assembly.
  always_comb begin
    sel_s = IMM_R;
    raw_s = 32'd0;
    case (inst[6:0])
      OPC_OP: begin
        sel_s = IMM_R;
        raw_s = 32'd0;
      end
      OPC_LOAD, OPC_OP_IMM: begin
        sel_s = IMM_I;
        raw_s = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        sel_s = IMM_S;
        raw_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        sel_s = IMM_B;
        raw_s = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_AUIPC, OPC_LUI: begin
        sel_s = IMM_U;
        raw_s = {inst[31:12], 12'd0};
      end
      OPC_JAL: begin
        sel_s = IMM_JAL;
        raw_s = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        sel_s = IMM_JALR;
        raw_s = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_SYSTEM: begin
        sel_s = IMM_CSR;
        raw_s = {27'd0, inst[19:15]};
      end
      default: begin
        sel_s = IMM_R;
        raw_s = 32'd0;
      end
    endcase
  end

  assign sel = sel_s;
  assign imm = sext32(raw_s);

`ifdef IMM_GEN_ILLEGAL_EN
  // Every legal opcode ends in 2'b11, so a non-11 low pair also lands here.
  assign illegal = (sel_s == IMM_R) && (inst[6:0] != OPC_OP);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator for decode with a valid/ready output stage.
// SKID=1: main + skid entry, in_ready registered (= skid empty), full rate.
// SKID=0: single output register, in_ready = !out_valid | out_ready.
// Optional macro IMM_GEN_ILLEGAL_EN adds the out_illegal port.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   input handshake, in_inst 32-bit instruction word
//   out_valid/out_ready output handshake
//   out_sel, out_imm    ImmSel code and XLEN-bit immediate
//   out_inst            instruction word carried alongside
//   out_illegal         unknown opcode flag (only with IMM_GEN_ILLEGAL_EN)
// -----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_inst
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

  // Payload layout (LSB first): inst[31:0], imm, sel, [illegal].
`ifdef IMM_GEN_ILLEGAL_EN
  localparam int PW = XLEN + 36;
`else
  localparam int PW = XLEN + 35;
`endif

  logic [2:0]      dec_sel_s;
  logic [XLEN-1:0] dec_imm_s;
  logic [PW-1:0]   new_s;
  logic [PW-1:0]   main_r;
  logic            main_valid_r;
  logic            in_ready_s;
  logic            accept_s;
  logic            consume_s;

`ifdef IMM_GEN_ILLEGAL_EN
  logic dec_illegal_s;

  imm_gen_comb #(.XLEN(XLEN)) u_dec (
    .inst    (in_inst),
    .sel     (dec_sel_s),
    .imm     (dec_imm_s),
    .illegal (dec_illegal_s)
  );

  assign new_s = {dec_illegal_s, dec_sel_s, dec_imm_s, in_inst};
`else
  imm_gen_comb #(.XLEN(XLEN)) u_dec (
    .inst (in_inst),
    .sel  (dec_sel_s),
    .imm  (dec_imm_s)
  );

  assign new_s = {dec_sel_s, dec_imm_s, in_inst};
`endif

  assign accept_s  = in_valid & in_ready_s;
  assign consume_s = main_valid_r & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [PW-1:0] skid_r;
      logic          skid_valid_r;
      logic          main_valid_nxt_s;
      logic          skid_valid_nxt_s;
      logic          load_new_s;
      logic          load_skid_s;
      logic          promote_s;

      // Skid only fills while main is held, so main is never empty with skid full.
      assign in_ready_s = ~skid_valid_r;

      // Entry steering: promote skid, load main directly, or park in skid.
      always_comb begin
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        load_new_s       = 1'b0;
        load_skid_s      = 1'b0;
        promote_s        = 1'b0;
        if (skid_valid_r) begin
          if (consume_s) begin
            promote_s        = 1'b1;
            main_valid_nxt_s = 1'b1;
            skid_valid_nxt_s = 1'b0;
          end else begin
            promote_s = 1'b0;
          end
        end else if (!main_valid_r || consume_s) begin
          main_valid_nxt_s = accept_s;
          load_new_s       = accept_s;
        end else begin
          if (accept_s) begin
            load_skid_s      = 1'b1;
            skid_valid_nxt_s = 1'b1;
          end else begin
            load_skid_s = 1'b0;
          end
        end
      end

      // Main and skid entry registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid_r <= 1'b0;
          main_r       <= {PW{1'b0}};
          skid_valid_r <= 1'b0;
          skid_r       <= {PW{1'b0}};
        end else begin
          main_valid_r <= main_valid_nxt_s;
          skid_valid_r <= skid_valid_nxt_s;
          if (promote_s) begin
            main_r <= skid_r;
          end else if (load_new_s) begin
            main_r <= new_s;
          end
          if (load_skid_s) begin
            skid_r <= new_s;
          end
        end
      end
    end else begin : g_noskid
      // Combinational path from out_ready: a consumed word is replaced in place.
      assign in_ready_s = ~main_valid_r | out_ready;

      // Single output register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid_r <= 1'b0;
          main_r       <= {PW{1'b0}};
        end else if (in_ready_s) begin
          main_valid_r <= in_valid;
          if (accept_s) begin
            main_r <= new_s;
          end
        end
      end
    end
  endgenerate

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_r;
  assign out_inst  = main_r[31:0];
  assign out_imm   = main_r[XLEN+31:32];
  assign out_sel   = main_r[XLEN+34:XLEN+32];
`ifdef IMM_GEN_ILLEGAL_EN
  assign out_illegal = main_r[XLEN+35];
`endif

endmodule
